// File: rtl/m_d_flit_asm.sv
// Memory-to-data-cache flit assembler: packs up to MAX_FLITS ring flits into one bundle for the
// m_d areg stage. Define M_D_ASM_ERR_EN to add the asm_err output and the DROP recovery state.
module m_d_flit_asm #(
  parameter int unsigned FLIT_W    = 16,
  parameter int unsigned MAX_FLITS = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_W-1:0]           flit_in,
  input  logic [1:0]                  flit_ctrl,
  input  logic                        v_flit_in,
  output logic                        flit_in_rdy,
  input  logic                        m_d_areg_state,
  output logic [FLIT_W*MAX_FLITS-1:0] m_flits_d,
  output logic                        v_m_flits_d
`ifdef M_D_ASM_ERR_EN
  ,
  output logic                        asm_err
`endif
);

  localparam int unsigned BUNDLE_W = FLIT_W * MAX_FLITS;
  localparam int unsigned CNT_W    = $clog2(MAX_FLITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FLITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
`ifdef M_D_ASM_ERR_EN
  localparam logic [1:0] ST_DROP    = 2'd3;
`endif

  localparam logic [1:0] CTRL_SINGLE = 2'b00;
  localparam logic [1:0] CTRL_HEAD   = 2'b01;
  localparam logic [1:0] CTRL_BODY   = 2'b10;
  localparam logic [1:0] CTRL_TAIL   = 2'b11;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BUNDLE_W-1:0] buf_q, buf_d;
  logic                accept;
  logic                wr_en;
  logic [CNT_W-1:0]    wr_slot;
  int unsigned         wr_lo;
`ifdef M_D_ASM_ERR_EN
  logic                err_q, err_d;
`endif

`ifdef M_D_ASM_ERR_EN
  assign flit_in_rdy = (state_q == ST_IDLE) || (state_q == ST_COLLECT) || (state_q == ST_DROP);
  assign asm_err     = err_q;
`else
  assign flit_in_rdy = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
`endif
  assign v_m_flits_d = (state_q == ST_FULL) && !m_d_areg_state;
  assign m_flits_d   = buf_q;
  assign accept      = v_flit_in && flit_in_rdy;

  // Slot k lives at the top of the bundle downwards: slot 0 occupies the MSBs.
  assign wr_lo = (MAX_FLITS - 1 - 32'(wr_slot)) * FLIT_W;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    wr_en   = 1'b0;
    wr_slot = '0;
`ifdef M_D_ASM_ERR_EN
    err_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (flit_ctrl)
            CTRL_SINGLE: begin
              wr_en   = 1'b1;
              state_d = ST_FULL;
            end
            CTRL_HEAD: begin
              wr_en   = 1'b1;
              cnt_d   = ONE_CNT;
              state_d = ST_COLLECT;
            end
            default: ;
          endcase
        end
      end

      ST_COLLECT: begin
        if (accept) begin
          case (flit_ctrl)
            CTRL_SINGLE, CTRL_HEAD: begin
              // A new message preempts the partial one; restart from slot 0.
              buf_d = '0;
              wr_en = 1'b1;
`ifdef M_D_ASM_ERR_EN
              err_d = 1'b1;
`endif
              if (flit_ctrl == CTRL_SINGLE) begin
                cnt_d   = '0;
                state_d = ST_FULL;
              end else begin
                cnt_d   = ONE_CNT;
                state_d = ST_COLLECT;
              end
            end
            CTRL_BODY: begin
              if (cnt_q < MAX_CNT) begin
                wr_en   = 1'b1;
                wr_slot = cnt_q;
                cnt_d   = cnt_q + ONE_CNT;
              end else begin
`ifdef M_D_ASM_ERR_EN
                err_d   = 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
                state_d = ST_DROP;
`endif
              end
            end
            CTRL_TAIL: begin
              // A tail arriving with every slot used completes the message unstored.
              if (cnt_q < MAX_CNT) begin
                wr_en   = 1'b1;
                wr_slot = cnt_q;
              end
              cnt_d   = '0;
              state_d = ST_FULL;
            end
            default: ;
          endcase
        end
      end

      ST_FULL: begin
        if (v_m_flits_d) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

`ifdef M_D_ASM_ERR_EN
      ST_DROP: begin
        if (accept) begin
          case (flit_ctrl)
            CTRL_SINGLE, CTRL_TAIL: state_d = ST_IDLE;
            CTRL_HEAD: begin
              wr_en   = 1'b1;
              cnt_d   = ONE_CNT;
              state_d = ST_COLLECT;
            end
            default: ;
          endcase
        end
      end
`endif

      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (wr_en) begin
      buf_d[wr_lo +: FLIT_W] = flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
`ifdef M_D_ASM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
`ifdef M_D_ASM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_m_d_flit_asm.sv
// Directed self-checking bench for m_d_flit_asm; overflow expectations follow M_D_ASM_ERR_EN.
module tb_m_d_flit_asm;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  flit_in;
  logic [1:0]   flit_ctrl;
  logic         v_flit_in;
  logic         flit_in_rdy;
  logic         m_d_areg_state;
  logic [143:0] m_flits_d;
  logic         v_m_flits_d;
`ifdef M_D_ASM_ERR_EN
  logic         asm_err;
`endif

  int total = 0;
  int bad   = 0;
  logic v_prev = 1'b0;

  m_d_flit_asm #(
    .FLIT_W   (16),
    .MAX_FLITS(9)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flit_in       (flit_in),
    .flit_ctrl     (flit_ctrl),
    .v_flit_in     (v_flit_in),
    .flit_in_rdy   (flit_in_rdy),
    .m_d_areg_state(m_d_areg_state),
    .m_flits_d     (m_flits_d),
    .v_m_flits_d   (v_m_flits_d)
`ifdef M_D_ASM_ERR_EN
    ,
    .asm_err       (asm_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bundle whose first n slots hold base, base+1, ...; remaining slots zero.
  function automatic logic [143:0] seq_bundle(input logic [15:0] base, input int n);
    logic [143:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[143-16*k -: 16] = base + 16'(k);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] ctrl, input logic [15:0] data);
    chk("rdy before send", {143'b0, flit_in_rdy}, 144'd1);
    flit_in   = data;
    flit_ctrl = ctrl;
    v_flit_in = 1'b1;
    @(posedge clk);
    #1;
    v_flit_in = 1'b0;
    #1;
  endtask

  // The bundle strobe must never be seen high on two consecutive cycles.
  always @(negedge clk) begin
    chk("no double v", {143'b0, v_prev && v_m_flits_d}, 144'd0);
    v_prev = v_m_flits_d;
  end

  initial begin
    rst            = 1'b1;
    flit_in        = '0;
    flit_ctrl      = '0;
    v_flit_in      = 1'b0;
    m_d_areg_state = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset rdy", {143'b0, flit_in_rdy}, 144'd1);
    chk("reset v", {143'b0, v_m_flits_d}, 144'd0);

    // Reset mid-collect discards the partial message.
    send(2'b01, 16'h1111);
    send(2'b10, 16'h2222);
    send(2'b10, 16'h3333);
    chk("partial pack", m_flits_d, {16'h1111, 16'h2222, 16'h3333, 96'h0});
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst mid rdy", {143'b0, flit_in_rdy}, 144'd1);
    chk("rst mid v", {143'b0, v_m_flits_d}, 144'd0);
    chk("rst mid data", m_flits_d, 144'h0);
`ifdef M_D_ASM_ERR_EN
    chk("rst mid err", {143'b0, asm_err}, 144'd0);
`endif

    // Single flit, one-cycle latency.
    send(2'b00, 16'hA5A5);
    chk("single v", {143'b0, v_m_flits_d}, 144'd1);
    chk("single data", m_flits_d, {16'hA5A5, 128'h0});
    chk("single rdy low", {143'b0, flit_in_rdy}, 144'd0);
    tick();
    chk("single idle v", {143'b0, v_m_flits_d}, 144'd0);
    chk("single idle data", m_flits_d, 144'h0);

    // Full 9-flit message.
    send(2'b01, 16'h1000);
    for (int i = 1; i < 8; i++) send(2'b10, 16'h1000 + 16'(i));
    chk("nine pre-tail v", {143'b0, v_m_flits_d}, 144'd0);
    send(2'b11, 16'h1008);
    chk("nine v", {143'b0, v_m_flits_d}, 144'd1);
    chk("nine data", m_flits_d, seq_bundle(16'h1000, 9));
    tick();

    // 3-flit message held under backpressure, released the same cycle busy drops.
    m_d_areg_state = 1'b1;
    send(2'b01, 16'h0001);
    send(2'b10, 16'h0002);
    send(2'b11, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      chk("bp rdy", {143'b0, flit_in_rdy}, 144'd0);
      chk("bp v", {143'b0, v_m_flits_d}, 144'd0);
      chk("bp data", m_flits_d, {48'h000100020003, 96'h0});
      tick();
    end
    m_d_areg_state = 1'b0;
    #1;
    chk("bp release v", {143'b0, v_m_flits_d}, 144'd1);
    chk("bp release data", m_flits_d, {48'h000100020003, 96'h0});
    tick();
    chk("bp after v", {143'b0, v_m_flits_d}, 144'd0);
    chk("bp after rdy", {143'b0, flit_in_rdy}, 144'd1);

    // Back-to-back: busy rises after the first handoff and holds for 4 cycles.
    send(2'b01, 16'h2001);
    send(2'b11, 16'h2002);
    chk("b2b first v", {143'b0, v_m_flits_d}, 144'd1);
    chk("b2b first data", m_flits_d, {16'h2001, 16'h2002, 112'h0});
    @(posedge clk);
    #1 m_d_areg_state = 1'b1;
    #1;
    send(2'b01, 16'h3001);
    send(2'b11, 16'h3002);
    chk("b2b held v", {143'b0, v_m_flits_d}, 144'd0);
    chk("b2b held data", m_flits_d, {16'h3001, 16'h3002, 112'h0});
    tick();
    chk("b2b held v2", {143'b0, v_m_flits_d}, 144'd0);
    tick();
    m_d_areg_state = 1'b0;
    #1;
    chk("b2b second v", {143'b0, v_m_flits_d}, 144'd1);
    chk("b2b second data", m_flits_d, {16'h3001, 16'h3002, 112'h0});
    tick();

    // Body in IDLE is discarded.
    send(2'b10, 16'h7777);
    chk("idle body ignored", m_flits_d, 144'h0);
    send(2'b00, 16'h7001);
    chk("after idle body", m_flits_d, {16'h7001, 128'h0});
    tick();

    // Head mid-message restarts at slot 0.
    send(2'b01, 16'h5001);
    send(2'b10, 16'h5002);
    send(2'b01, 16'h6001);
`ifdef M_D_ASM_ERR_EN
    chk("restart err", {143'b0, asm_err}, 144'd1);
`endif
    send(2'b11, 16'h6002);
    chk("restart v", {143'b0, v_m_flits_d}, 144'd1);
    chk("restart data", m_flits_d, {16'h6001, 16'h6002, 112'h0});
    tick();

    // Overflow: head plus 9 bodies, then a tail.
    send(2'b01, 16'h4000);
    for (int i = 1; i < 10; i++) send(2'b10, 16'h4000 + 16'(i));
`ifdef M_D_ASM_ERR_EN
    chk("ovf err", {143'b0, asm_err}, 144'd1);
    chk("ovf v", {143'b0, v_m_flits_d}, 144'd0);
    send(2'b11, 16'h400A);
    chk("ovf err clear", {143'b0, asm_err}, 144'd0);
    chk("ovf tail v", {143'b0, v_m_flits_d}, 144'd0);
    chk("ovf tail data", m_flits_d, 144'h0);
    chk("ovf idle rdy", {143'b0, flit_in_rdy}, 144'd1);
`else
    chk("ovf v", {143'b0, v_m_flits_d}, 144'd0);
    send(2'b11, 16'h400A);
    chk("ovf tail v", {143'b0, v_m_flits_d}, 144'd1);
    chk("ovf tail data", m_flits_d, seq_bundle(16'h4000, 9));
`endif
    tick();
    chk("final v", {143'b0, v_m_flits_d}, 144'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
